rd_dma_sched: RTL

- Round-robin scheduler that shares one rd_dma instance between N_CH requesters.
- Accepts one transfer descriptor (base address, byte size) per requester over a valid/ready handshake and grants one requester at a time.
- Programs the granted descriptor into rd_dma through rd_dma's Avalon-MM CSR slave, then polls its status register until the transfer completes or a timeout expires.
- Sits between the host/command logic and rd_dma's amm_slave_csr_* port.

---
 rtl/rd_dma_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rd_dma_sched.sv
// Round-robin front end that shares one rd_dma between N_CH requesters:
// grants a descriptor, programs it over the CSR port, then polls STATUS until idle or timeout.
module rd_dma_sched #(
  parameter int N_CH           = 4,
  parameter int AMM_CSR_DATA_W = 32,
  parameter int AMM_CSR_ADDR_W = 4,
  parameter int DMA_ADDR_W     = 32,
  parameter int SIZE_W         = 32,
  parameter int ADDR_BASE_ADDR = 0,
  parameter int ADDR_SIZE      = 1,
  parameter int ADDR_RUN       = 2,
  parameter int ADDR_STATUS    = 3,
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT        = 65535
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [N_CH-1:0]            req_valid_i,
  output logic [N_CH-1:0]            req_ready_o,
  input  logic [N_CH*DMA_ADDR_W-1:0] req_addr_i,
  input  logic [N_CH*SIZE_W-1:0]     req_size_i,
  output logic [N_CH-1:0]            done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [$clog2(N_CH)-1:0]    cur_ch_o,
  output logic [AMM_CSR_ADDR_W-1:0]  amm_master_csr_address_o,
  output logic                       amm_master_csr_read_o,
  input  logic [AMM_CSR_DATA_W-1:0]  amm_master_csr_readdata_i,
  output logic                       amm_master_csr_write_o,
  output logic [AMM_CSR_DATA_W-1:0]  amm_master_csr_writedata_o
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int POLL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_BASE, ST_WR_SIZE, ST_WR_RUN,
    ST_POLL_GAP, ST_RD_STAT, ST_RD_WAIT, ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ptr_reg;
  logic [CH_W-1:0]     cur_ch_reg;
  logic [DMA_ADDR_W-1:0] addr_reg;
  logic [SIZE_W-1:0]   size_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [POLL_W-1:0]   poll_cnt_reg;
  logic                err_reg;

  logic [DMA_ADDR_W-1:0] ch_addr [N_CH];
  logic [SIZE_W-1:0]     ch_size [N_CH];
  logic [CH_W-1:0]       rot_idx [N_CH];
  logic [N_CH-1:0]       rot_valid;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_ch;
  logic                  grant;
  logic                  stat_busy;
  logic                  poll_timeout;
  logic                  unused_rdata;

  // Channel slices, rotated so slot 0 is the channel the pointer names.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_addr[gi]   = req_addr_i[gi*DMA_ADDR_W +: DMA_ADDR_W];
      assign ch_size[gi]   = req_size_i[gi*SIZE_W +: SIZE_W];
      assign rot_idx[gi]   = CH_W'((int'(ptr_reg) + gi) % N_CH);
      assign rot_valid[gi] = req_valid_i[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        grant_found = 1'b1;
        grant_ch    = rot_idx[i];
      end
    end
  end

  assign grant        = (state_reg == ST_IDLE) && grant_found && !srst_i;
  assign stat_busy    = amm_master_csr_readdata_i[0];
  assign poll_timeout = (poll_cnt_reg == POLL_W'(TIMEOUT - 1));
  assign unused_rdata = ^amm_master_csr_readdata_i[AMM_CSR_DATA_W-1:1];
  assign cur_ch_o     = cur_ch_reg;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      cur_ch_reg   <= '0;
      addr_reg     <= '0;
      size_reg     <= '0;
      gap_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= (state_reg == ST_POLL_GAP) ? gap_cnt_reg + GAP_W'(1) : '0;
      if (grant) begin
        ptr_reg      <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
        cur_ch_reg   <= grant_ch;
        addr_reg     <= ch_addr[grant_ch];
        size_reg     <= ch_size[grant_ch];
        poll_cnt_reg <= '0;
        err_reg      <= 1'b0;
      end
      // Each busy status costs one poll; the last allowed poll flags the abort.
      if (state_reg == ST_RD_WAIT && stat_busy) begin
        if (poll_timeout) err_reg <= 1'b1;
        else              poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
      end
    end
  end

  always_comb begin
    state_next                 = state_reg;
    req_ready_o                = '0;
    done_o                     = '0;
    err_o                      = 1'b0;
    busy_o                     = 1'b0;
    amm_master_csr_address_o   = '0;
    amm_master_csr_read_o      = 1'b0;
    amm_master_csr_write_o     = 1'b0;
    amm_master_csr_writedata_o = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          req_ready_o[grant_ch] = 1'b1;
          state_next = (ch_size[grant_ch] == '0) ? ST_DONE : ST_WR_BASE;
        end
      end
      ST_WR_BASE: begin
        busy_o                     = 1'b1;
        amm_master_csr_write_o     = 1'b1;
        amm_master_csr_address_o   = AMM_CSR_ADDR_W'(ADDR_BASE_ADDR);
        amm_master_csr_writedata_o = AMM_CSR_DATA_W'(addr_reg);
        state_next                 = ST_WR_SIZE;
      end
      ST_WR_SIZE: begin
        busy_o                     = 1'b1;
        amm_master_csr_write_o     = 1'b1;
        amm_master_csr_address_o   = AMM_CSR_ADDR_W'(ADDR_SIZE);
        amm_master_csr_writedata_o = AMM_CSR_DATA_W'(size_reg);
        state_next                 = ST_WR_RUN;
      end
      ST_WR_RUN: begin
        busy_o                     = 1'b1;
        amm_master_csr_write_o     = 1'b1;
        amm_master_csr_address_o   = AMM_CSR_ADDR_W'(ADDR_RUN);
        amm_master_csr_writedata_o = AMM_CSR_DATA_W'(1);
        state_next                 = ST_POLL_GAP;
      end
      ST_POLL_GAP: begin
        busy_o = 1'b1;
        if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) state_next = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        busy_o                   = 1'b1;
        amm_master_csr_read_o    = 1'b1;
        amm_master_csr_address_o = AMM_CSR_ADDR_W'(ADDR_STATUS);
        state_next               = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        busy_o = 1'b1;
        if (!stat_busy || poll_timeout) state_next = ST_DONE;
        else                            state_next = ST_POLL_GAP;
      end
      ST_DONE: begin
        done_o[cur_ch_reg] = 1'b1;
        err_o              = err_reg;
        state_next         = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
